square_scheduler: RTL

- Shares one meta_multiplier (OP_WIDTH x OP_WIDTH -> 2*OP_WIDTH, unsigned, combinational, clk/rst_n unused) among N_CH sample channels inside ThresholdCutter/square.
- Round-robin arbitrates per-channel valid/ready requests and drives src0 = src1 = operand to square each sample.
- Returns the square tagged with the channel index through a 2-stage registered pipeline with full backpressure.

---
 rtl/square_pkg.sv | 22 ++
 rtl/square_scheduler_if.sv | 34 +++
 rtl/meta_multiplier.sv | 20 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/square_scheduler.sv | 126 ++++++++++++
 5 files changed

// File: rtl/square_pkg.sv
// Shared constants and helpers for the square scheduler.
//   clog2   : ceiling log2 of a positive integer
//   ch_w    : width of a channel index, never narrower than one bit
package square_pkg;

    localparam int unsigned OP_WIDTH_DEF = 16;
    localparam int unsigned N_CH_DEF     = 8;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned ch_w(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/square_scheduler_if.sv
// Request/result bundle of the square scheduler.
//   in_valid/in_data/in_ready : per-channel sample requests (channel i at [i*OP_WIDTH +: OP_WIDTH])
//   out_valid/out_ready       : result handshake
//   out_ch/out_result         : channel tag and squared sample
//   busy                      : a pipeline stage holds a sample
// master = requester/consumer side, slave = scheduler side.
interface square_scheduler_if
    import square_pkg::*;
#(
    parameter int unsigned OP_WIDTH = OP_WIDTH_DEF,
    parameter int unsigned N_CH     = N_CH_DEF,
    parameter int unsigned CH_W     = ch_w(N_CH)
) ();

    logic [N_CH-1:0]          in_valid;
    logic [N_CH*OP_WIDTH-1:0] in_data;
    logic [N_CH-1:0]          in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH_W-1:0]          out_ch;
    logic [2*OP_WIDTH-1:0]    out_result;
    logic                     busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_ch, out_result, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_ch, out_result, busy
    );

endinterface

// File: rtl/meta_multiplier.sv
// Unsigned combinational multiplier, WIDTH x WIDTH -> 2*WIDTH.
//   clk/rst_n : present for interface compatibility, not used
//   src0/src1 : operands
//   dst       : product
module meta_multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   src0,
    input  logic [WIDTH-1:0]   src1,
    output logic [2*WIDTH-1:0] dst
);

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign dst = {{WIDTH{1'b0}}, src0} * {{WIDTH{1'b0}}, src1};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches req starting one past ptr, wrapping modulo N_CH.
//   req   : per-channel requests
//   ptr   : last granted channel
//   en    : when low no grant is issued
//   grant : one-hot (or zero) grant
//   idx   : encoded index of the grant (0 when none)
module rr_arbiter #(
    parameter int unsigned N_CH = 8,
    parameter int unsigned CH_W = 3
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            en,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] idx
);

    always_comb begin
        int unsigned c;
        logic        found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            c = (32'(ptr) + k) % N_CH;
            if (en && !found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = CH_W'(c);
            end
        end
    end

endmodule

// File: rtl/square_scheduler.sv
// Shares one multiplier among N_CH channels to square their samples.
// Round-robin arbitration feeds a 2-stage pipeline (operand reg, result reg)
// with full backpressure; results come back tagged with their channel.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/result bundle (slave side)
module square_scheduler
    import square_pkg::*;
#(
    parameter int unsigned OP_WIDTH = OP_WIDTH_DEF,
    parameter int unsigned N_CH     = N_CH_DEF,
    parameter int unsigned SIGNED   = 1
) (
    input  logic             clk,
    input  logic             rst,
    square_scheduler_if.slave bus
);

    localparam int unsigned CH_W = ch_w(N_CH);
    localparam int unsigned RW   = 2 * OP_WIDTH;

    logic                s1_valid_q, s1_valid_d;
    logic [CH_W-1:0]     s1_ch_q, s1_ch_d;
    logic [OP_WIDTH-1:0] s1_op_q, s1_op_d;
    logic                out_valid_q, out_valid_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;
    logic [RW-1:0]       out_result_q, out_result_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                adv1, adv2, accept;
    logic [N_CH-1:0]     grant;
    logic [CH_W-1:0]     grant_idx;
    logic [OP_WIDTH-1:0] samples [N_CH];
    logic [OP_WIDTH-1:0] sample, operand;
    logic [RW-1:0]       product;

    assign adv2 = !out_valid_q || bus.out_ready;
    assign adv1 = !s1_valid_q || adv2;

    // Gating with rst keeps in_ready low for the whole reset cycle.
    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req   (bus.in_valid),
        .ptr   (rr_ptr_q),
        .en    (adv1 && !rst),
        .grant (grant),
        .idx   (grant_idx)
    );

    // A grant only exists for an asserted request, so any grant is a handshake.
    assign accept       = |grant;
    assign bus.in_ready = grant;

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            samples[i] = bus.in_data[i*OP_WIDTH +: OP_WIDTH];
        end
        sample = samples[grant_idx];
        // Most negative value negates to itself and still squares correctly unsigned.
        if (SIGNED != 0 && sample[OP_WIDTH-1]) begin
            operand = ~sample + OP_WIDTH'(1);
        end else begin
            operand = sample;
        end
    end

    meta_multiplier #(
        .WIDTH (OP_WIDTH)
    ) u_mult (
        .clk   (1'b0),
        .rst_n (1'b1),
        .src0  (s1_op_q),
        .src1  (s1_op_q),
        .dst   (product)
    );

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_ch_d      = s1_ch_q;
        s1_op_d      = s1_op_q;
        out_valid_d  = out_valid_q;
        out_ch_d     = out_ch_q;
        out_result_d = out_result_q;
        rr_ptr_d     = rr_ptr_q;
        if (adv1) begin
            s1_valid_d = accept;
            s1_ch_d    = grant_idx;
            s1_op_d    = operand;
        end
        if (adv2) begin
            out_valid_d  = s1_valid_q;
            out_ch_d     = s1_ch_q;
            out_result_d = product;
        end
        if (accept) begin
            rr_ptr_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_ch_q      <= '0;
            s1_op_q      <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_result_q <= '0;
            rr_ptr_q     <= CH_W'(N_CH - 1);
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_ch_q      <= s1_ch_d;
            s1_op_q      <= s1_op_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_result_q <= out_result_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_result = out_result_q;
    assign bus.busy       = s1_valid_q || out_valid_q;

endmodule
